// File: rtl/spi_multi_controller_if.sv
// CIA-side register bus between the bus buffer and the SPI/IRQ controller.
// master = CPU/bus-buffer side, slave = controller side.
interface spi_multi_controller_if;
  logic       r_w;
  logic       _cs;
  logic       e;
  logic [3:0] rs;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output r_w, _cs, e, rs, data_in, input  data_out, data_oe);
  modport slave  (input  r_w, _cs, e, rs, data_in, output data_out, data_oe);
endinterface

// File: rtl/spi_multi_controller.sv
// Register-mapped 8-bit SPI master (mode 0, MSB first) with NUM_SS selects,
// programmable SCLK rate and a maskable active-low interrupt concentrator.

// One registered active-low select line.
module spi_mc_ss_lane #(
  parameter int IDX = 0
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic [2:0] sel,
  output logic       ss
);
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) ss <= 1'b1;
    else         ss <= (sel != 3'(IDX));
endmodule

module spi_multi_controller #(
  parameter int         NUM_SS    = 4,
  parameter int         NUM_IRQ   = 2,
  parameter logic [3:0] DATA_ADDR = 4'hb,
  parameter logic [3:0] CTRL_ADDR = 4'he,
  parameter int         HALF_BASE = 2
) (
  input  logic                clk,
  input  logic                _reset,
  spi_multi_controller_if.slave bus,
  input  logic [NUM_SS-1:0]   miso,
  output logic                mosi,
  output logic                sclk,
  output logic [NUM_SS-1:0]   _ss,
  input  logic [NUM_IRQ-1:0]  _dev_irq,
  output logic                int_req
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t state, state_d;

  logic [2:0]         e_pipe;
  logic               e_sync, e_fall;
  logic               wr_stb, data_wr, ctrl_wr;
  logic [NUM_IRQ-1:0] irq_s0, irq_s1;
  logic               irq_pend;

  logic [2:0]  sel, pend_sel;
  logic [1:0]  div, pend_div;
  logic        ien, pend_vld;
  logic        busy, apply_now;
  logic [7:0]  ctrl_rd;

  logic [15:0] half, tmr;
  logic        tmr_hit;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, rx;
  logic        samp, miso_bit;
  logic        ld, rise, fall, done;

  // e: two sync flops plus one history flop for the falling-edge detect
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) e_pipe <= '0;
    else         e_pipe <= {e_pipe[1:0], bus.e};

  assign e_sync  = e_pipe[1];
  assign e_fall  = e_pipe[2] & ~e_pipe[1];
  assign wr_stb  = e_fall & ~bus._cs & ~bus.r_w;
  assign data_wr = wr_stb & (bus.rs == DATA_ADDR);
  assign ctrl_wr = wr_stb & (bus.rs == CTRL_ADDR);

  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      irq_s0 <= '1;
      irq_s1 <= '1;
    end else begin
      irq_s0 <= _dev_irq;
      irq_s1 <= irq_s0;
    end

  assign irq_pend = |(~irq_s1);

  always_ff @(posedge clk or negedge _reset)
    if (!_reset) int_req <= 1'b0;
    else         int_req <= ien & irq_pend;

  assign busy = (state != IDLE);

  // SEL/DIV written mid-transfer are parked and land on the transfer's last edge
  assign apply_now = ctrl_wr & (~busy | done);

  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      sel      <= 3'd7;
      div      <= 2'd0;
      ien      <= 1'b0;
      pend_vld <= 1'b0;
      pend_sel <= 3'd7;
      pend_div <= 2'd0;
    end else begin
      if (ctrl_wr) ien <= bus.data_in[5];
      if (apply_now) begin
        sel      <= bus.data_in[2:0];
        div      <= bus.data_in[4:3];
        pend_vld <= 1'b0;
      end else if (ctrl_wr) begin
        pend_vld <= 1'b1;
        pend_sel <= bus.data_in[2:0];
        pend_div <= bus.data_in[4:3];
      end else if (done && pend_vld) begin
        sel      <= pend_sel;
        div      <= pend_div;
        pend_vld <= 1'b0;
      end
    end

  assign ctrl_rd = {busy, irq_pend, ien, div, sel};

  assign bus.data_oe = ~bus._cs & bus.r_w & e_sync &
                       ((bus.rs == DATA_ADDR) | (bus.rs == CTRL_ADDR));

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.rs == CTRL_ADDR)      bus.data_out = ctrl_rd;
    else if (bus.rs == DATA_ADDR) bus.data_out = rx;
  end

  for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
    spi_mc_ss_lane #(.IDX(i)) u_lane (
      .clk    (clk),
      ._reset (_reset),
      .sel    (sel),
      .ss     (_ss[i])
    );
  end

  // Unselected (or out-of-range SEL) reads back as 1s
  always_comb begin
    miso_bit = 1'b1;
    for (int i = 0; i < NUM_SS; i++)
      if (sel == 3'(i)) miso_bit = miso[i];
  end

  assign half    = 16'(HALF_BASE) << div;
  assign tmr_hit = (tmr == half - 16'd1);

  always_ff @(posedge clk or negedge _reset)
    if (!_reset) state <= IDLE;
    else         state <= state_d;

  always_comb begin
    state_d = state;
    ld      = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (data_wr) begin
        ld      = 1'b1;
        state_d = LOW;
      end
      LOW: if (tmr_hit) begin
        rise    = 1'b1;
        state_d = HIGH;
      end
      HIGH: if (tmr_hit) begin
        fall = 1'b1;
        if (bit_cnt == 3'd7) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      tmr     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      samp    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      rx      <= 8'hFF;
    end else if (ld) begin
      shreg   <= bus.data_in;
      mosi    <= bus.data_in[7];
      sclk    <= 1'b0;
      tmr     <= '0;
      bit_cnt <= '0;
    end else if (rise) begin
      sclk <= 1'b1;
      samp <= miso_bit;
      tmr  <= '0;
    end else if (fall) begin
      sclk  <= 1'b0;
      tmr   <= '0;
      shreg <= {shreg[6:0], samp};
      if (done) begin
        rx      <= {shreg[6:0], samp};
        mosi    <= 1'b1;
        bit_cnt <= '0;
      end else begin
        mosi    <= shreg[6];
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else if (busy) begin
      tmr <= tmr + 16'd1;
    end

endmodule

// File: tb/tb_spi_multi_controller.sv
// Directed bench for spi_multi_controller: register reads go through a
// scoreboard queue; SPI line activity is captured by a negedge monitor.
module tb_spi_multi_controller;
  localparam logic [3:0] DA = 4'hb;
  localparam logic [3:0] CA = 4'he;

  logic       clk = 1'b0;
  logic       _reset;
  logic [3:0] miso;
  logic       mosi, sclk, int_req;
  logic [3:0] _ss;
  logic [1:0] _dev_irq;

  always #5 clk = ~clk;

  spi_multi_controller_if bus();

  spi_multi_controller #(.NUM_SS(4), .NUM_IRQ(2), .DATA_ADDR(DA), .CTRL_ADDR(CA), .HALF_BASE(2)) dut (
    .clk(clk), ._reset(_reset), .bus(bus), .miso(miso), .mosi(mosi),
    .sclk(sclk), ._ss(_ss), ._dev_irq(_dev_irq), .int_req(int_req)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct { string name; logic [7:0] exp; } rd_t;
  rd_t sb_q[$];

  // scoreboard monitor: one pop per read presented by the DUT
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    oe_prev <= bus.data_oe;
    if (bus.data_oe && !oe_prev) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: data_out=0x%0h with no expected entry", bus.data_out);
      end else begin
        rd_t t;
        t = sb_q.pop_front();
        chk(t.name, {24'h0, bus.data_out}, {24'h0, t.exp});
      end
    end
  end

  // SPI line monitor
  int         cyc = 0, rises = 0, falls = 0;
  int         rise_cyc [0:1023];
  int         fall_cyc [0:1023];
  logic       sclk_prev = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= sclk;
    if (sclk && !sclk_prev) begin
      if (rises < 1024) rise_cyc[rises] <= cyc;
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[6:0], mosi};
    end
    if (!sclk && sclk_prev) begin
      if (falls < 1024) fall_cyc[falls] <= cyc;
      falls <= falls + 1;
    end
  end

  // slave model: shifts slv_byte out MSB first, advancing on each sclk fall
  int         slv_idx = -1, slv_base = 0;
  logic [7:0] slv_byte = 8'h00;
  always_comb begin
    logic [2:0] bp;
    miso = '0;
    bp   = 3'(7 - (falls - slv_base));
    for (int i = 0; i < 4; i++)
      if (i == slv_idx && (falls - slv_base) >= 0 && (falls - slv_base) < 8)
        miso[i] = slv_byte[bp];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    tick(1);
    bus.rs = a; bus.data_in = d; bus.r_w = 1'b0; bus._cs = 1'b0; bus.e = 1'b1;
    tick(4);
    bus.e = 1'b0;
    tick(5);
    bus._cs = 1'b1; bus.r_w = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    rd_t t;
    t.name = name; t.exp = exp;
    sb_q.push_back(t);
    tick(1);
    bus.rs = a; bus.r_w = 1'b1; bus._cs = 1'b0; bus.e = 1'b1;
    tick(5);
    bus.e = 1'b0;
    tick(2);
    bus._cs = 1'b1;
  endtask

  task automatic wait_falls(input int base, input int n, input int budget, input string name);
    int k = 0;
    while ((falls - base) < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, 32'(falls - base), 32'(n));
  endtask

  int rb, fb;

  initial begin : global_timeout
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    _reset = 1'b0; _dev_irq = 2'b11;
    bus.r_w = 1'b1; bus._cs = 1'b1; bus.e = 1'b0; bus.rs = 4'h0; bus.data_in = 8'h00;
    tick(3);
    chk("rst_ss", {28'h0, _ss}, 32'hF);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h1);
    chk("rst_int_req", {31'h0, int_req}, 32'h0);
    chk("rst_oe", {31'h0, bus.data_oe}, 32'h0);
    _reset = 1'b1;
    tick(2);
    bus_read(CA, 8'h07, "rst_ctrl");
    bus_read(DA, 8'hFF, "rst_data");

    // T2: SEL=1, DIV=0, A5 out / 3C in
    bus_write(CA, 8'h01);
    tick(2);
    chk("t2_ss", {28'h0, _ss}, 32'hD);
    slv_idx = 1; slv_byte = 8'h3C; slv_base = falls; rb = rises; fb = falls;
    bus_write(DA, 8'hA5);
    wait_falls(fb, 8, 200, "t2_falls");
    chk("t2_rises", 32'(rises - rb), 32'd8);
    chk("t2_mosi", {24'h0, mosi_cap}, 32'hA5);
    chk("t2_half", 32'(fall_cyc[fb+7] - rise_cyc[rb+7]), 32'd2);
    chk("t2_span", 32'(fall_cyc[fb+7] - rise_cyc[rb]), 32'd30);
    bus_read(DA, 8'h3C, "t2_rx");
    bus_read(CA, 8'h01, "t2_ctrl");

    // T3: DIV=3, second DATA write mid-transfer is dropped
    bus_write(CA, 8'h18);
    slv_idx = 0; slv_byte = 8'h96; slv_base = falls; rb = rises; fb = falls;
    bus_write(DA, 8'h5A);
    tick(80);
    bus_write(DA, 8'hFF);
    bus_read(CA, 8'h98, "t3_busy_ctrl");
    wait_falls(fb, 8, 400, "t3_falls");
    chk("t3_mosi", {24'h0, mosi_cap}, 32'h5A);
    chk("t3_half", 32'(fall_cyc[fb+7] - rise_cyc[rb+7]), 32'd16);
    chk("t3_span", 32'(fall_cyc[fb+7] - rise_cyc[rb]), 32'd240);
    tick(40);
    chk("t3_rises", 32'(rises - rb), 32'd8);
    bus_read(DA, 8'h96, "t3_rx");

    // T4: no slave selected; miso[0] held low must be ignored
    bus_write(CA, 8'h07);
    slv_idx = 0; slv_byte = 8'h00; slv_base = falls; rb = rises; fb = falls;
    bus_write(DA, 8'h00);
    tick(3);
    chk("t4_ss", {28'h0, _ss}, 32'hF);
    wait_falls(fb, 8, 200, "t4_falls");
    chk("t4_rises", 32'(rises - rb), 32'd8);
    bus_read(DA, 8'hFF, "t4_rx");

    // T5: interrupt concentrator
    bus_write(CA, 8'h27);
    tick(2);
    chk("t5_irq_idle", {31'h0, int_req}, 32'h0);
    _dev_irq = 2'b01;
    tick(3);
    chk("t5_irq_set", {31'h0, int_req}, 32'h1);
    bus_read(CA, 8'h67, "t5_ctrl_pend");
    bus_write(CA, 8'h07);
    chk("t5_irq_masked", {31'h0, int_req}, 32'h0);
    bus_read(CA, 8'h47, "t5_ctrl_masked");
    _dev_irq = 2'b11;
    tick(4);
    bus_read(CA, 8'h07, "t5_ctrl_clear");

    // T6: address decode and deferred SEL/DIV
    tick(1);
    bus.rs = 4'h3; bus.r_w = 1'b1; bus._cs = 1'b0; bus.e = 1'b1;
    tick(4);
    chk("t6_rs3_oe", {31'h0, bus.data_oe}, 32'h0);
    bus.e = 1'b0; bus._cs = 1'b1;
    tick(3);
    bus.rs = DA; bus.e = 1'b1;
    tick(4);
    chk("t6_cs_oe", {31'h0, bus.data_oe}, 32'h0);
    bus.e = 1'b0;
    tick(3);
    bus_write(CA, 8'h08);
    slv_idx = -1; rb = rises; fb = falls;
    bus_write(DA, 8'h11);
    bus_write(CA, 8'h0A);
    chk("t6_ss_held", {28'h0, _ss}, 32'hE);
    bus_read(CA, 8'h88, "t6_ctrl_held");
    wait_falls(fb, 8, 300, "t6_falls");
    tick(3);
    chk("t6_ss_new", {28'h0, _ss}, 32'hB);
    bus_read(CA, 8'h0A, "t6_ctrl_new");
    bus_read(DA, 8'h00, "t6_rx");

    // T1: reset mid-transfer
    bus_write(CA, 8'h01);
    bus_write(DA, 8'hA5);
    tick(5);
    _reset = 1'b0;
    #2;
    chk("t1_ss", {28'h0, _ss}, 32'hF);
    chk("t1_sclk", {31'h0, sclk}, 32'h0);
    chk("t1_mosi", {31'h0, mosi}, 32'h1);
    tick(2);
    _reset = 1'b1;
    rb = rises;
    tick(40);
    chk("t1_aborted", 32'(rises - rb), 32'd0);
    bus_read(CA, 8'h07, "t1_ctrl");
    bus_read(DA, 8'hFF, "t1_data");

    tick(5);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
